debug_capture_ctrl: RTL and testbench

- Sequences port 2 (s2) of the CurrCTRL dual-port debug RAM as a triggered circular capture buffer.
- Streams current-loop samples into the RAM with a programmable pre-trigger depth, then stops after the post-trigger window.
- Reports the start address of the record so the CPU can unroll the capture through port 1 (s1).

---
 rtl/debug_capture_ctrl.sv | 155 +++++++++++++++
 tb/tb_debug_capture_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/debug_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : debug_capture_ctrl
// Purpose  : Drives port 2 of the CurrCTRL debug RAM as a triggered circular
//            capture buffer with a programmable pre-trigger depth.
// Revision : 1.0 - initial release
// ============================================================================
module debug_capture_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic              trigger,
  input  logic [ADDR_W-1:0] pretrig_len,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_write,
  output logic              ram_chipselect,
  output logic [3:0]        ram_byteenable,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] trig_addr
);

  // DEPTH held in ADDR_W+1 bits so a full post window (pre_len = 0) fits
  localparam logic [ADDR_W:0]   DEPTH_W  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   POST_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              trig_hit;
  logic              start;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] pre_len;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W:0]   post_cnt;
  logic [ADDR_W:0]   post_full;

  // Number of post-trigger samples needed to complete a DEPTH-word record
  assign post_full      = DEPTH_W - {1'b0, pre_len};
  assign ram_chipselect = ram_write;
  assign ram_byteenable = 4'hF;
  assign busy           = (state == ST_FILL) || (state == ST_ARMED) || (state == ST_POST);
  assign done           = (state == ST_DONE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; abort overrides arm, trigger and sample acceptance
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    trig_hit  = 1'b0;
    start     = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            start     = 1'b1;
            state_nxt = (pretrig_len != '0) ? ST_FILL : ST_ARMED;
          end
        end
        ST_FILL: begin
          accept = sample_valid;
          if (sample_valid && (pre_cnt + PTR_ONE == pre_len)) state_nxt = ST_ARMED;
        end
        ST_ARMED: begin
          accept = sample_valid;
          if (trigger) begin
            trig_hit = 1'b1;
            // A coincident sample is itself the first post-trigger word
            if (sample_valid && (post_full == POST_ONE)) state_nxt = ST_DONE;
            else                                         state_nxt = ST_POST;
          end
        end
        ST_POST: begin
          accept = sample_valid;
          if (sample_valid && (post_cnt == POST_ONE)) state_nxt = ST_DONE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Registered RAM write port: an accepted sample appears one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_write     <= 1'b0;
      ram_address   <= '0;
      ram_writedata <= '0;
    end else begin
      ram_write <= accept;
      if (accept) begin
        ram_address   <= wr_ptr;
        ram_writedata <= sample_data;
      end
    end
  end

  // Write pointer, window counters and record addresses
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      pre_len    <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      trig_addr  <= '0;
      start_addr <= '0;
    end else if (abort) begin
      wr_ptr   <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
    end else if (start) begin
      pre_len  <= pretrig_len;
      wr_ptr   <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if ((state == ST_FILL) && accept) pre_cnt <= pre_cnt + PTR_ONE;
      if (trig_hit) begin
        trig_addr <= wr_ptr;
        post_cnt  <= sample_valid ? (post_full - POST_ONE) : post_full;
      end else if ((state == ST_POST) && accept) begin
        post_cnt <= post_cnt - POST_ONE;
      end
      // Oldest sample of the record sits pre_len words before the trigger point
      if ((state_nxt == ST_DONE) && (state != ST_DONE))
        start_addr <= (trig_hit ? wr_ptr : trig_addr) - pre_len;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debug_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_capture_ctrl
// Purpose  : Scoreboard bench for debug_capture_ctrl (ADDR_W=4, DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_capture_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset;
  logic          arm;
  logic          abort;
  logic          trigger;
  logic [AW-1:0] pretrig_len;
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_writedata;
  logic          ram_write;
  logic          ram_chipselect;
  logic [3:0]    ram_byteenable;
  logic          busy;
  logic          done;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] trig_addr;

  debug_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .arm            (arm),
    .abort          (abort),
    .trigger        (trigger),
    .pretrig_len    (pretrig_len),
    .sample_valid   (sample_valid),
    .sample_data    (sample_data),
    .ram_address    (ram_address),
    .ram_writedata  (ram_writedata),
    .ram_write      (ram_write),
    .ram_chipselect (ram_chipselect),
    .ram_byteenable (ram_byteenable),
    .busy           (busy),
    .done           (done),
    .start_addr     (start_addr),
    .trig_addr      (trig_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  // Reference model: a capture is a count of samples written since arm, the
  // index at which the trigger was taken, and the size of the pre window.
  bit            m_armed = 1'b0;
  bit            m_fin   = 1'b0;
  int            m_written = 0;
  int            m_trig_idx = -1;
  int            m_pre = 0;
  logic [AW-1:0] m_trig_addr = '0;
  logic [AW-1:0] m_start = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model(input bit r, input bit a, input bit ab, input bit tr,
                       input bit v, input logic [AW-1:0] pl, input logic [DW-1:0] d);
    wr_t e;
    if (r) begin
      m_armed = 1'b0; m_fin = 1'b0; m_trig_addr = '0; m_start = '0;
    end else if (ab) begin
      m_armed = 1'b0; m_fin = 1'b0;
    end else if (!m_armed || m_fin) begin
      if (a) begin
        m_armed = 1'b1; m_fin = 1'b0; m_written = 0; m_trig_idx = -1; m_pre = int'(pl);
      end
    end else begin
      if (tr && m_trig_idx < 0 && m_written >= m_pre) begin
        m_trig_idx  = m_written;
        m_trig_addr = AW'(m_written % DEPTH);
      end
      if (v) begin
        e.cyc  = cyc;
        e.addr = AW'(m_written % DEPTH);
        e.data = d;
        exp_q.push_back(e);
        m_written++;
      end
      if (m_trig_idx >= 0 && (m_written - m_trig_idx) == DEPTH - m_pre) begin
        m_fin   = 1'b1;
        m_start = AW'((int'(m_trig_addr) - m_pre + DEPTH) % DEPTH);
      end
    end
  endtask

  // One clock of stimulus; the model and status checks run just after the edge
  task automatic step(input bit r, input bit a, input bit ab, input bit tr,
                      input bit v, input logic [AW-1:0] pl);
    logic [DW-1:0] d;
    d = $urandom;
    reset = r; arm = a; abort = ab; trigger = tr; sample_valid = v;
    pretrig_len = pl; sample_data = d;
    @(posedge clk);
    #1;
    model(r, a, ab, tr, v, pl, d);
    chk("busy", 32'(busy), 32'(m_armed && !m_fin));
    chk("done", 32'(done), 32'(m_armed && m_fin));
    chk("trig_addr", 32'(trig_addr), 32'(m_trig_addr));
    chk("start_addr", 32'(start_addr), 32'(m_start));
  endtask

  task automatic run_until_done(input int max_cycles);
    for (int i = 0; i < max_cycles && !m_fin; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, ($urandom % 4) != 0, AW'($urandom));
    chk("done_within_bound", 32'(done), 32'd1);
  endtask

  // Monitor: every RAM write must match the oldest expected write, in its cycle
  always @(negedge clk) begin : mon
    bit  exp_wr;
    wr_t e;
    if (mon_en) begin
      exp_wr = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
      chk("ram_write", 32'(ram_write), 32'(exp_wr));
      chk("ram_chipselect", 32'(ram_chipselect), 32'(exp_wr));
      chk("ram_byteenable", 32'(ram_byteenable), 32'hF);
      if (exp_wr) begin
        e = exp_q.pop_front();
        chk("ram_address", 32'(ram_address), 32'(e.addr));
        chk("ram_writedata", ram_writedata, e.data);
      end
    end
  end

  initial begin
    reset = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
    sample_valid = 1'b0; pretrig_len = '0; sample_data = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    mon_en = 1'b1;
    chk("reset_ram_write", 32'(ram_write), 32'd0);
    chk("reset_ram_address", 32'(ram_address), 32'd0);
    chk("reset_ram_writedata", ram_writedata, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);

    // Pre 4 then trigger together with the next sample: exactly 16 writes
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9);
    run_until_done(100);
    chk("s1_trig_addr", 32'(trig_addr), 32'd4);
    chk("s1_start_addr", 32'(start_addr), 32'd0);

    // Long ARMED phase wraps the pointer before the trigger
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
    for (int i = 0; i < 34; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4);
    run_until_done(100);
    chk("s2_trig_addr", 32'(trig_addr), 32'd2);
    chk("s2_start_addr", 32'(start_addr), 32'd14);

    // Pure post-trigger capture, trigger on the first sample
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    run_until_done(100);
    chk("s3_trig_addr", 32'(trig_addr), 32'd0);
    chk("s3_start_addr", 32'(start_addr), 32'd0);

    // Abort after 3 post-trigger writes, then restart from address 0
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
    chk("s4_busy_after_abort", 32'(busy), 32'd0);
    chk("s4_done_after_abort", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2);
    run_until_done(100);

    // 1-of-3 valid duty with trigger pulses during FILL
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6);
    for (int i = 0; i < 18; i++)
      step(1'b0, 1'b0, 1'b0, (i % 2) == 1, (i % 3) == 0, 4'd6);
    for (int i = 0; i < 120 && !m_fin; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, (i % 3) == 0, 4'd6);
    chk("s5_done", 32'(done), 32'd1);

    // arm while busy is ignored; reset mid-ARMED returns to reset values
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd9);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd9);
    chk("s6_reset_ram_address", 32'(ram_address), 32'd0);
    chk("s6_reset_ram_writedata", ram_writedata, 32'd0);
    chk("s6_reset_ram_write", 32'(ram_write), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);

    // Randomized captures with random duty, triggers, arms and rare aborts
    for (int n = 0; n < 8; n++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0, ($urandom % 2) == 0, AW'($urandom));
      for (int i = 0; i < 250 && m_armed && !m_fin; i++)
        step(1'b0, ($urandom % 16) == 0, ($urandom % 200) == 0, ($urandom % 8) == 0,
             ($urandom % 3) != 0, AW'($urandom));
    end

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
